ntt_addr_gen: RTL
=================

# ntt_addr_gen

Parametrised address sequencer for radix-2 in-place NTT/INTT butterflies. It emits one butterfly (u, v, twiddle index) per beat through a valid/ready handshake, so a stalled butterfly pipeline or memory port holds the sequence. The mode is selected per transform: forward Cooley-Tukey stage order or inverse Gentleman-Sande reverse stage order. It sits between the transform controller (start/abort/done) and the coefficient RAM / twiddle ROM address ports.

## Interface
- N_LOG, 3, log2 of transform length; legal range 1..16; N = 1 << N_LOG
- SW, $clog2(N_LOG+1), width of stage output (localparam)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- inv  in  1  0 = forward (stages 1..N_LOG), 1 = inverse (stages N_LOG..1); latched at start
- abort  in  1  synchronous cancel, any state
- out_valid  out  1  current beat valid
- out_ready  in  1  consumer accepts beat when out_valid && out_ready
- addr_u  out  N_LOG  first butterfly operand address
- addr_v  out  N_LOG  second operand address
- addr_w  out  N_LOG  twiddle index (MSB always 0)
- stage  out  SW  current stage s, 1..N_LOG
- tw_inv  out  1  latched inv, selects inverse twiddle table
- last  out  1  high on final beat of the transform only
- busy  out  1  high in WORK and DONE
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, WORK, DONE.
- IDLE: start=1 latches inv, loads the first stage (s=1 fwd, s=N_LOG inv), k=0, j=0, and goes to WORK.
- Per stage s: m = 2^s, half = m/2, stride = N/m.
- Loop order: j (0..half-1) innermost, then k (0..N-m, step m), then stage outermost.
- Beat fields: u = k+j, v = k+j+half, w = j*stride.
- Stage advance: fwd s+1 (m<<1, stride>>1); inv s-1 (m>>1, stride<<1).
- Total beats: N_LOG * N/2.
- Internal counters are N_LOG+1 bits wide. u, v < N and w < N/2, so truncation to N_LOG bits is lossless. The multiply is replaced by a running w accumulator (+stride per j, cleared at j wrap).
- An accepted beat advances the counters. A final accepted beat moves the block to DONE.
- DONE: done=1 and out_valid=0 for one cycle, then IDLE. start held high retriggers from IDLE, giving back-to-back transforms.
- start while busy is ignored. inv changes mid-transform are ignored.
- abort=1: next state IDLE, out_valid=0, no done pulse. abort has priority over start and over beat acceptance in the same cycle.
- N_LOG=1: a single beat (0,1,0) with last=1.

## Timing
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: out_valid, addr_u, addr_v, addr_w, stage, tw_inv, last, busy, done. Internal counters 0.
- All outputs are registered.
- start sampled at edge T: out_valid=1 from T+1 with the first beat.
- Throughput: with out_ready held high, one beat per cycle, no bubbles, including across k and stage boundaries.
- Stall: out_valid && !out_ready freezes addr_u, addr_v, addr_w, stage, last and tw_inv. out_valid does not drop while stalled.
- Last beat accepted at edge L: out_valid=0 and done=1 during cycle L+1. IDLE at L+2, and start is sampled there.
- Reset or abort mid-transform leaves no residual valid beat.

## Structure
- Package ntt_pkg holds:
  - state enum: IDLE, WORK, DONE
  - mode constants: NTT_FWD=0, NTT_INV=1
  - function ntt_beats(N_LOG), returns N_LOG*2^(N_LOG-1)
- Sub-module ntt_loop_ctr: nested j/k/stage counters with an advance input. It outputs u, v, w, stage, and the wrap flags (j_wrap, k_wrap, final). Direction is selected by inv.
- The top level owns the FSM, the handshake and the output registers.

## Test plan
- N_LOG=3, fwd, out_ready=1: 12 consecutive beats (u,v,w) = (0,1,0)(2,3,0)(4,5,0)(6,7,0) (0,2,0)(1,3,2)(4,6,0)(5,7,2) (0,4,0)(1,5,1)(2,6,2)(3,7,3). last on beat 12. done exactly 1 cycle later.
- N_LOG=3, inv: stage 3 beats first, (0,4,0)..(3,7,3), then stage 2, then stage 1. Final beat (6,7,0) with last=1, stage=1, tw_inv=1 throughout.
- Random out_ready (~50%) on N_LOG=4, fwd: accepted-beat stream identical to the unstalled reference model (32 beats). Outputs stable during every stall.
- abort asserted on beat 5 with out_ready=1: out_valid=0 next cycle, no done. A new start produces beat (0,1,0) again.
- rst_n pulsed low mid-transform (asynchronous, between edges): all outputs 0 immediately. start after release runs a full 12-beat sequence.
- start held high across two N_LOG=1 transforms: beats (0,1,0) last=1, done, idle, (0,1,0) last=1, done. start pulse during WORK is ignored (beat count still 12 for N_LOG=3).

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the radix-2 NTT address sequencer.
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORK = 2'd1,
        DONE = 2'd2
    } ntt_state_t;

    localparam logic NTT_FWD = 1'b0;
    localparam logic NTT_INV = 1'b1;

    // Butterflies per transform: N_LOG stages of N/2 butterflies each.
    function automatic int ntt_beats(input int n_log);
        return n_log * (1 << (n_log - 1));
    endfunction

endpackage

// File: rtl/ntt_loop_ctr.sv
// Nested j/k/stage loop counters for in-place radix-2 butterflies.
// Outputs describe the beat the counters are about to hold (next state).
module ntt_loop_ctr
    import ntt_pkg::*;
#(
    parameter  int N_LOG = 3,
    localparam int CW    = N_LOG + 1,
    localparam int SW    = $clog2(N_LOG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_inv,
    input  logic             i_advance,
    output logic [N_LOG-1:0] o_u,
    output logic [N_LOG-1:0] o_v,
    output logic [N_LOG-1:0] o_w,
    output logic [SW-1:0]    o_stage,
    output logic             o_j_wrap,
    output logic             o_k_wrap,
    output logic             o_final
);

    localparam logic [CW-1:0] N_VAL = CW'(1) << N_LOG;

    logic [CW-1:0] r_j, r_k, r_w, r_m, r_stride;
    logic [SW-1:0] r_s;
    logic          r_inv;
    logic          r_jw, r_kw;

    logic [CW-1:0] w_nj, w_nk, w_nw, w_nm, w_nstride, w_nhalf;
    logic [SW-1:0] w_ns;
    logic          w_ninv;
    logic          w_jw, w_kw, w_fin;

    // w replaces j*stride with a running sum that restarts at every j wrap.
    always_comb begin
        w_nj      = r_j;
        w_nk      = r_k;
        w_nw      = r_w;
        w_nm      = r_m;
        w_nstride = r_stride;
        w_ns      = r_s;
        w_ninv    = r_inv;
        if (i_load) begin
            w_ninv = i_inv;
            w_nj   = '0;
            w_nk   = '0;
            w_nw   = '0;
            if (i_inv == NTT_INV) begin
                w_ns      = SW'(N_LOG);
                w_nm      = N_VAL;
                w_nstride = CW'(1);
            end else begin
                w_ns      = SW'(1);
                w_nm      = CW'(2);
                w_nstride = N_VAL >> 1;
            end
        end else if (i_advance) begin
            if (!r_jw) begin
                w_nj = r_j + CW'(1);
                w_nw = r_w + r_stride;
            end else begin
                w_nj = '0;
                w_nw = '0;
                if (!r_kw) begin
                    w_nk = r_k + r_m;
                end else begin
                    w_nk = '0;
                    if (r_inv == NTT_INV) begin
                        w_ns      = r_s - SW'(1);
                        w_nm      = r_m >> 1;
                        w_nstride = r_stride << 1;
                    end else begin
                        w_ns      = r_s + SW'(1);
                        w_nm      = r_m << 1;
                        w_nstride = r_stride >> 1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_nhalf = w_nm >> 1;
        w_jw    = (w_nj == w_nhalf - CW'(1));
        w_kw    = (w_nk == N_VAL - w_nm);
        w_fin   = (w_ninv == NTT_INV) ? (w_ns == SW'(1)) : (w_ns == SW'(N_LOG));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j      <= '0;
            r_k      <= '0;
            r_w      <= '0;
            r_m      <= '0;
            r_stride <= '0;
            r_s      <= '0;
            r_inv    <= 1'b0;
            r_jw     <= 1'b0;
            r_kw     <= 1'b0;
        end else begin
            r_j      <= w_nj;
            r_k      <= w_nk;
            r_w      <= w_nw;
            r_m      <= w_nm;
            r_stride <= w_nstride;
            r_s      <= w_ns;
            r_inv    <= w_ninv;
            r_jw     <= w_jw;
            r_kw     <= w_kw;
        end
    end

    // u, v < N and w < N/2, so dropping the counter MSB loses nothing.
    assign o_u      = w_nk[N_LOG-1:0] + w_nj[N_LOG-1:0];
    assign o_v      = o_u + w_nhalf[N_LOG-1:0];
    assign o_w      = w_nw[N_LOG-1:0];
    assign o_stage  = w_ns;
    assign o_j_wrap = w_jw;
    assign o_k_wrap = w_kw;
    assign o_final  = w_fin;

endmodule

// File: rtl/ntt_addr_gen.sv
// Radix-2 NTT/INTT butterfly address sequencer with a valid/ready output beat.
// Owns the IDLE/WORK/DONE control FSM and all registered outputs.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter  int N_LOG = 3,
    localparam int SW    = $clog2(N_LOG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inv,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_LOG-1:0] addr_u,
    output logic [N_LOG-1:0] addr_v,
    output logic [N_LOG-1:0] addr_w,
    output logic [SW-1:0]    stage,
    output logic             tw_inv,
    output logic             last,
    output logic             busy,
    output logic             done
);

    ntt_state_t       r_state, w_state_n;
    logic             r_out_valid, r_tw_inv, r_last, r_busy, r_done;
    logic [N_LOG-1:0] r_addr_u, r_addr_v, r_addr_w;
    logic [SW-1:0]    r_stage;

    logic             w_valid_n, w_tw_inv_n, w_last_n, w_done_n;
    logic [N_LOG-1:0] w_addr_u_n, w_addr_v_n, w_addr_w_n;
    logic [SW-1:0]    w_stage_n;
    logic             w_load, w_advance, w_accept;

    logic [N_LOG-1:0] w_ctr_u, w_ctr_v, w_ctr_w;
    logic [SW-1:0]    w_ctr_stage;
    logic             w_ctr_j_wrap, w_ctr_k_wrap, w_ctr_final;

    assign w_accept = r_out_valid && out_ready;

    ntt_loop_ctr #(.N_LOG(N_LOG)) u_loop_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_inv     (inv),
        .i_advance (w_advance),
        .o_u       (w_ctr_u),
        .o_v       (w_ctr_v),
        .o_w       (w_ctr_w),
        .o_stage   (w_ctr_stage),
        .o_j_wrap  (w_ctr_j_wrap),
        .o_k_wrap  (w_ctr_k_wrap),
        .o_final   (w_ctr_final)
    );

    // The counters step in the same cycle a beat is accepted, so the next
    // beat lands in the output registers on that edge with no bubble.
    always_comb begin
        w_state_n  = r_state;
        w_valid_n  = r_out_valid;
        w_tw_inv_n = r_tw_inv;
        w_last_n   = r_last;
        w_done_n   = 1'b0;
        w_addr_u_n = r_addr_u;
        w_addr_v_n = r_addr_v;
        w_addr_w_n = r_addr_w;
        w_stage_n  = r_stage;
        w_load     = 1'b0;
        w_advance  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_state_n  = WORK;
                    w_valid_n  = 1'b1;
                    w_tw_inv_n = inv;
                end
            end
            WORK: begin
                if (w_accept) begin
                    if (r_last) begin
                        w_state_n = DONE;
                        w_valid_n = 1'b0;
                        w_last_n  = 1'b0;
                        w_done_n  = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase

        if (abort) begin
            w_state_n = IDLE;
            w_valid_n = 1'b0;
            w_last_n  = 1'b0;
            w_done_n  = 1'b0;
            w_load    = 1'b0;
            w_advance = 1'b0;
        end

        if (w_load || w_advance) begin
            w_addr_u_n = w_ctr_u;
            w_addr_v_n = w_ctr_v;
            w_addr_w_n = w_ctr_w;
            w_stage_n  = w_ctr_stage;
            w_last_n   = w_ctr_j_wrap && w_ctr_k_wrap && w_ctr_final;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_tw_inv    <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_u    <= '0;
            r_addr_v    <= '0;
            r_addr_w    <= '0;
            r_stage     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_out_valid <= w_valid_n;
            r_tw_inv    <= w_tw_inv_n;
            r_last      <= w_last_n;
            r_busy      <= (w_state_n != IDLE);
            r_done      <= w_done_n;
            r_addr_u    <= w_addr_u_n;
            r_addr_v    <= w_addr_v_n;
            r_addr_w    <= w_addr_w_n;
            r_stage     <= w_stage_n;
        end
    end

    assign out_valid = r_out_valid;
    assign addr_u    = r_addr_u;
    assign addr_v    = r_addr_v;
    assign addr_w    = r_addr_w;
    assign stage     = r_stage;
    assign tw_inv    = r_tw_inv;
    assign last      = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
